bkram_sd_ctrl: RTL and testbench

//  Multi-slot backup-RAM save/load sequencer between the cart NVRAM dual-port buffer and the SD sector interface.
//  - Transfers SECTORS x 512-byte sectors per request, with one save slot per file region.
//  - Tracks NVRAM dirtiness and aborts stalled transfers with a watchdog.
//  - Sits in the core top beside hps_io. Its loading output is OR'd into system reset.

---
 rtl/bkram_pkg.sv | 12 +
 rtl/bkram_wdog.sv | 23 ++
 rtl/bkram_sd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bkram_sd_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkram_pkg.sv
// Shared types for the backup-RAM SD save/load sequencer.
package bkram_pkg;
    localparam int SECTOR_BYTES = 512;

    typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, ABORT} bkram_state_t;
    typedef enum logic [1:0] {RQ_NONE, RQ_LOAD, RQ_SAVE} bkram_req_t;

    // $clog2 with a floor of one bit, so single-entry configurations still get a real vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bkram_wdog.sv
// Loadable down-counter: clr reloads LOAD, en counts down to zero, expired flags zero.
module bkram_wdog #(
    parameter int           W    = 8,
    parameter logic [W-1:0] LOAD = '1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset || clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/bkram_sd_ctrl.sv
// Multi-slot backup-RAM save/load sequencer between cart NVRAM and the SD sector interface.
// Optional auto-save after a quiet period is enabled by defining BKRAM_AUTOSAVE_EN.
module bkram_sd_ctrl
    import bkram_pkg::*;
#(
    parameter int SECTORS      = 64,
    parameter int SLOTS        = 4,
    parameter int TIMEOUT      = 16777215,
    parameter int AUTOSAVE_CYC = 54000000
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          bk_ena,
    input  logic                          img_nz,
    input  logic                          dl_done,
    input  logic                          load_req,
    input  logic                          save_req,
    input  logic [clog2_min1(SLOTS)-1:0]  slot,
    input  logic                          nvram_we,
    input  logic                          sd_ack,
    output logic [31:0]                   sd_lba,
    output logic                          sd_rd,
    output logic                          sd_wr,
    output logic                          busy,
    output logic                          loading,
    output logic                          dirty,
    output logic                          done,
    output logic                          err
);
    localparam int CNT_W  = clog2_min1(SECTORS);
    localparam int SLOT_W = clog2_min1(SLOTS);
    localparam int TO_W   = clog2_min1(TIMEOUT);

    bkram_state_t      state, state_nxt;
    bkram_req_t        req, op;
    logic [SLOT_W-1:0] req_slot;
    logic [CNT_W-1:0]  sec_cnt;
    logic              load_q, save_q, ack_q;
    logic              load_edge, save_edge, ack_rise, ack_fall;
    logic              accept, last_sec, to_expired;

    assign load_edge = load_req & bk_ena & ~load_q;
    assign save_edge = save_req & bk_ena & ~save_q;
    assign ack_rise  = sd_ack & ~ack_q;
    assign ack_fall  = ~sd_ack & ack_q;
    assign last_sec  = (sec_cnt == CNT_W'(SECTORS - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            load_q <= 1'b0;
            save_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            load_q <= load_req & bk_ena;
            save_q <= save_req & bk_ena;
            ack_q  <= sd_ack;
        end
    end

    // The watchdog only runs while waiting for an ack; any other state rearms it.
    bkram_wdog #(.W(TO_W), .LOAD(TO_W'(TIMEOUT - 1))) u_timeout (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (to_expired)
    );

`ifdef BKRAM_AUTOSAVE_EN
    localparam int AS_W = clog2_min1(AUTOSAVE_CYC);
    logic              as_expired;
    logic [SLOT_W-1:0] last_slot;

    bkram_wdog #(.W(AS_W), .LOAD(AS_W'(AUTOSAVE_CYC - 1))) u_autosave (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (nvram_we),
        .en      (dirty & bk_ena & (state == IDLE)),
        .expired (as_expired)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_slot <= '0;
        end else if (accept) begin
            last_slot <= req_slot;
        end
    end
`endif

    // Request arbitration: download-complete load, then manual load, save, auto-save.
    always_comb begin
        req      = RQ_NONE;
        req_slot = slot;
        if (bk_ena) begin
            if (dl_done && img_nz) begin
                req      = RQ_LOAD;
                req_slot = '0;
            end else if (load_edge) begin
                req = RQ_LOAD;
            end else if (save_edge) begin
                req = RQ_SAVE;
`ifdef BKRAM_AUTOSAVE_EN
            end else if (as_expired && dirty) begin
                req      = RQ_SAVE;
                req_slot = last_slot;
`endif
            end
        end
    end

    assign accept = (state == IDLE) && (req != RQ_NONE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ: begin
                if (ack_rise)        state_nxt = XFER;
                else if (to_expired) state_nxt = ABORT;
            end
            XFER:    if (ack_fall) state_nxt = last_sec ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_lba  <= '0;
            sec_cnt <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            loading <= 1'b0;
            err     <= 1'b0;
            op      <= RQ_NONE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sd_lba  <= 32'(req_slot) * 32'(SECTORS);
                    sec_cnt <= '0;
                    op      <= req;
                    sd_rd   <= (req == RQ_LOAD);
                    sd_wr   <= (req == RQ_SAVE);
                    loading <= (req == RQ_LOAD);
                    err     <= 1'b0;
                end
                REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end else if (to_expired) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        loading <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                XFER: if (ack_fall && !last_sec) begin
                    sd_lba  <= sd_lba + 32'd1;
                    sec_cnt <= sec_cnt + 1'b1;
                    sd_rd   <= (op == RQ_LOAD);
                    sd_wr   <= (op == RQ_SAVE);
                end
                DONE:    loading <= 1'b0;
                default: ;
            endcase
        end
    end

    // A system write wins over a same-cycle save accept so no modification is lost.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if (nvram_we && !loading) begin
            dirty <= 1'b1;
        end else if ((accept && (req == RQ_SAVE)) || ((state == DONE) && (op == RQ_LOAD))) begin
            dirty <= 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Bench for bkram_sd_ctrl: random SD host responder, event scoreboard and directed scenarios.
`timescale 1ns/1ps
module tb_bkram_sd_ctrl;
    localparam int SECTORS      = 4;
    localparam int SLOTS        = 4;
    localparam int TIMEOUT      = 100;
    localparam int AUTOSAVE_CYC = 50;

    localparam logic [1:0] EV_ERR  = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_WR   = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    logic        clk_sys, reset, bk_ena, img_nz, dl_done, load_req, save_req, nvram_we, sd_ack;
    logic [1:0]  slot;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, busy, loading, dirty, done, err;

    int          total;
    int          bad;
    logic [33:0] exp_q[$];
    bit          ack_en;
    int          exp_last;

    bkram_sd_ctrl #(
        .SECTORS(SECTORS), .SLOTS(SLOTS), .TIMEOUT(TIMEOUT), .AUTOSAVE_CYC(AUTOSAVE_CYC)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .img_nz(img_nz),
        .dl_done(dl_done), .load_req(load_req), .save_req(save_req), .slot(slot),
        .nvram_we(nvram_we), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .busy(busy), .loading(loading), .dirty(dirty), .done(done), .err(err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic check1(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, want);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Reference: a transfer of slot s touches LBAs s*SECTORS .. s*SECTORS+SECTORS-1 in order.
    task automatic push_xfer(input logic [1:0] kind, input int s, input int nsec, input bit with_done);
        for (int i = 0; i < nsec; i++) exp_q.push_back({kind, 32'(s * SECTORS + i)});
        if (with_done) exp_q.push_back({EV_DONE, 32'd0});
    endtask

    task automatic mon_event(input logic [1:0] kind, input logic [31:0] lba);
        logic [33:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got kind %0d lba %0d, expected no event", kind, lba);
        end else begin
            e = exp_q.pop_front();
            if (e !== {kind, lba}) begin
                bad++;
                $display("FAIL event: got kind %0d lba %0d, expected kind %0d lba %0d",
                         kind, lba, e[33:32], e[31:0]);
            end
        end
    endtask

    task automatic wait_idle(input string name, input logic want_loading);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            if (!done) check1({name, "_loading"}, loading, want_loading);
            @(negedge clk_sys);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s_idle: busy still 1 after %0d cycles, expected 0", name, n);
        end
    endtask

    // SD host: answers each rd/wr with a randomly delayed ack pulse.
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en && !reset && (sd_rd || sd_wr)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                sd_ack = 1'b1;
                @(negedge clk_sys);
                check1("req_drop_on_ack", sd_rd | sd_wr, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    // Monitor: every request rise, done pulse and err rise must match the next expected event.
    initial begin
        logic p_rd, p_wr, p_err;
        p_rd = 1'b0;
        p_wr = 1'b0;
        p_err = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (sd_rd && !p_rd) mon_event(EV_RD, sd_lba);
                if (sd_wr && !p_wr) mon_event(EV_WR, sd_lba);
                if (done)           mon_event(EV_DONE, 32'd0);
                if (err && !p_err)  mon_event(EV_ERR, 32'd0);
            end
            p_rd  = sd_rd;
            p_wr  = sd_wr;
            p_err = err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, s, base;
        bit is_load, we_mid;
        total = 0; bad = 0; ack_en = 1'b1; exp_last = 0;
        reset = 1'b1; bk_ena = 1'b0; img_nz = 1'b0; dl_done = 1'b0;
        load_req = 1'b0; save_req = 1'b0; nvram_we = 1'b0; slot = 2'd0;
        cyc(3);
        check1("rst_busy", busy, 1'b0);
        check1("rst_rd", sd_rd, 1'b0);
        check1("rst_wr", sd_wr, 1'b0);
        check1("rst_loading", loading, 1'b0);
        check1("rst_dirty", dirty, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_lba", sd_lba, 32'd0);
        reset = 1'b0; bk_ena = 1'b1;
        cyc(2);

        // Save of slot 2
        nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
        check1("t1_dirty_set", dirty, 1'b1);
        push_xfer(EV_WR, 2, SECTORS, 1);
        slot = 2'd2; save_req = 1'b1; cyc(1); save_req = 1'b0; exp_last = 2;
        check1("t1_busy", busy, 1'b1);
        wait_idle("t1", 1'b0);
        check1("t1_dirty", dirty, 1'b0);
        check1("t1_err", err, 1'b0);

        // Download-complete load of slot 0; writes during the load do not dirty
        nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
        check1("t2_dirty_pre", dirty, 1'b1);
        push_xfer(EV_RD, 0, SECTORS, 1);
        img_nz = 1'b1; slot = 2'd3; dl_done = 1'b1; cyc(1); dl_done = 1'b0; exp_last = 0;
        check1("t2_loading", loading, 1'b1);
        cyc(2); nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
        wait_idle("t2", 1'b1);
        check1("t2_dirty", dirty, 1'b0);

        // Gated requests: empty image, unmounted save image
        img_nz = 1'b0; dl_done = 1'b1; cyc(1); dl_done = 1'b0; cyc(3);
        check1("nz_gate_busy", busy, 1'b0);
        img_nz = 1'b1;
        bk_ena = 1'b0; save_req = 1'b1; cyc(1); save_req = 1'b0; cyc(3);
        check1("ena_gate_busy", busy, 1'b0);
        bk_ena = 1'b1;

        // Watchdog abort, then the next request clears err
        ack_en = 1'b0;
        exp_q.push_back({EV_RD, 32'(1 * SECTORS)});
        exp_q.push_back({EV_ERR, 32'd0});
        slot = 2'd1; load_req = 1'b1; cyc(1); load_req = 1'b0; exp_last = 1;
        check1("t3_rd", sd_rd, 1'b1);
        cyc(TIMEOUT - 1);
        check1("t3_err_c99", err, 1'b0);
        check1("t3_busy_c99", busy, 1'b1);
        cyc(1);
        check1("t3_err_c100", err, 1'b1);
        check1("t3_rd_c100", sd_rd, 1'b0);
        cyc(1);
        check1("t3_busy_c101", busy, 1'b0);
        check1("t3_err_c101", err, 1'b1);
        check1("t3_loading_c101", loading, 1'b0);
        ack_en = 1'b1;
        push_xfer(EV_WR, 3, SECTORS, 1);
        slot = 2'd3; save_req = 1'b1; cyc(1); save_req = 1'b0; exp_last = 3;
        check1("t3_err_cleared", err, 1'b0);
        wait_idle("t3", 1'b0);

        // Coincident load/save: load wins; a save edge mid-transfer is dropped
        push_xfer(EV_RD, 1, SECTORS, 1);
        slot = 2'd1; load_req = 1'b1; save_req = 1'b1; cyc(1); exp_last = 1;
        check1("t4_loading", loading, 1'b1);
        save_req = 1'b0; cyc(3); save_req = 1'b1; cyc(2);
        save_req = 1'b0; load_req = 1'b0;
        wait_idle("t4", 1'b1);
        cyc(5);
        check1("t4_no_extra", busy, 1'b0);

        // Reset while in XFER of the last sector
        base = 2 * SECTORS;
        push_xfer(EV_RD, 2, SECTORS, 0);
        slot = 2'd2; load_req = 1'b1; cyc(1); load_req = 1'b0;
        n = 0;
        while (!(busy && !sd_rd && sd_lba == 32'(base + SECTORS - 1)) && n < 500) begin
            cyc(1);
            n++;
        end
        check1("t5_reach_xfer", (n < 500), 1'b1);
        reset = 1'b1; cyc(1);
        check1("t5_rd", sd_rd, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check1("t5_loading", loading, 1'b0);
        reset = 1'b0; exp_last = 0;
        cyc(20);
        check32("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random transactions against the slot/LBA and dirty rules
        for (int it = 0; it < 12; it++) begin
            s       = $urandom_range(0, SLOTS - 1);
            is_load = 1'($urandom_range(0, 1));
            we_mid  = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 4));
            nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
            check1("rnd_dirty_pre", dirty, 1'b1);
            push_xfer(is_load ? EV_RD : EV_WR, s, SECTORS, 1);
            slot = s[1:0];
            if (is_load) load_req = 1'b1;
            else         save_req = 1'b1;
            cyc(1);
            load_req = 1'b0; save_req = 1'b0; exp_last = s;
            check1("rnd_busy", busy, 1'b1);
            if (we_mid) begin
                cyc(2); nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
            end
            wait_idle("rnd", is_load);
            check1("rnd_dirty_post", dirty, !is_load && we_mid);
        end

`ifdef BKRAM_AUTOSAVE_EN
        // Quiet-period auto-save of the last accepted slot, restarted by a second write
        cyc(2);
        nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
        cyc(29);
        nvram_we = 1'b1; cyc(1); nvram_we = 1'b0;
        push_xfer(EV_WR, exp_last, SECTORS, 1);
        cyc(AUTOSAVE_CYC - 1);
        check1("as_not_yet", sd_wr, 1'b0);
        cyc(1);
        check1("as_start", sd_wr, 1'b1);
        wait_idle("as", 1'b0);
`endif

        cyc(5);
        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
